// File: rtl/cfg_frame_pkg.sv
// Shared constants, FSM states, error codes and payload type for the config frame controller.
package cfg_frame_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 28;
    localparam int unsigned ERR_W  = 3;

    localparam logic [BYTE_W-1:0] SOF = 8'hFF;
    localparam logic [BYTE_W-1:0] EOF = 8'hFE;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHK   = 3'd3,
        ST_END   = 3'd4,
        ST_ISSUE = 3'd5
    } state_e;

    localparam logic [ERR_W-1:0] ERR_NONE     = 3'd0;
    localparam logic [ERR_W-1:0] ERR_BAD_ADDR = 3'd1;
    localparam logic [ERR_W-1:0] ERR_OVERFLOW = 3'd2;
    localparam logic [ERR_W-1:0] ERR_BAD_CHK  = 3'd3;
    localparam logic [ERR_W-1:0] ERR_BAD_END  = 3'd4;
    localparam logic [ERR_W-1:0] ERR_RESYNC   = 3'd5;
    localparam logic [ERR_W-1:0] ERR_OVERRUN  = 3'd6;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT  = 3'd7;

    // Register-bank write payload
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cfg_word_t;

endpackage

// File: rtl/frame_timeout_timer.sv
// Inter-byte idle timer: counts while enabled, clears on reload, flags the last allowed cycle.
module frame_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic reload,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: held at zero while disabled, restarted by each byte, saturates at LAST
    always_comb begin
        cnt_d = cnt_q;
        if (!enable || reload) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register, synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/cfg_frame_controller.sv
// Parses FF/ADDR/D3..D0/CHK/FE UART frames and issues valid/ready writes to the DDS register bank.
module cfg_frame_controller
    import cfg_frame_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              cfg_valid,
    input  logic              cfg_ready,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [DATA_W-1:0] cfg_data,
    output logic              frame_err,
    output logic [ERR_W-1:0]  err_code,
    output logic              busy
);

    state_e            state_q, state_d;
    cfg_word_t         cfg_q, cfg_d;
    logic [BYTE_W-1:0] chk_q, chk_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              cfg_valid_q, cfg_valid_d;
    logic              frame_err_q, frame_err_d;
    logic [ERR_W-1:0]  err_code_q, err_code_d;
    logic              busy_q;
    logic              tmo_en;
    logic              tmo_expired;

    assign tmo_en = (state_q == ST_ADDR) || (state_q == ST_DATA) ||
                    (state_q == ST_CHK)  || (state_q == ST_END);

    frame_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (tmo_en),
        .reload  (rx_valid),
        .expired (tmo_expired)
    );

    // Frame parser next-state, accumulators and error reporting
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        chk_d       = chk_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        cfg_valid_d = cfg_valid_q;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == SOF)) begin
                    state_d = ST_ADDR;
                    cfg_d   = '0;
                    chk_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_ADDR, ST_DATA, ST_CHK, ST_END: begin
                if (rx_valid) begin
                    // A start byte mid-frame restarts the frame; in END it is just a bad terminator
                    if ((rx_data == SOF) && (state_q != ST_END)) begin
                        state_d     = ST_ADDR;
                        cfg_d       = '0;
                        chk_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_RESYNC;
                    end else begin
                        case (state_q)
                            ST_ADDR: begin
                                cfg_d.addr = rx_data[ADDR_W-1:0];
                                chk_d      = rx_data;
                                if (rx_data > 8'h03) begin
                                    state_d     = ST_IDLE;
                                    frame_err_d = 1'b1;
                                    err_code_d  = ERR_BAD_ADDR;
                                end else begin
                                    state_d = ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                cfg_d.data = {cfg_q.data[DATA_W-BYTE_W-1:0], rx_data};
                                chk_d      = chk_q ^ rx_data;
                                cnt_d      = cnt_q + 2'd1;
                                if ((cnt_q == 2'd0) && (rx_data[7:4] != 4'h0)) begin
                                    ovf_d = 1'b1;
                                end
                                if (cnt_q == 2'd3) begin
                                    state_d = ST_CHK;
                                end
                            end
                            ST_CHK: begin
                                if (ovf_q) begin
                                    state_d     = ST_IDLE;
                                    frame_err_d = 1'b1;
                                    err_code_d  = ERR_OVERFLOW;
                                end else if (rx_data != chk_q) begin
                                    state_d     = ST_IDLE;
                                    frame_err_d = 1'b1;
                                    err_code_d  = ERR_BAD_CHK;
                                end else begin
                                    state_d = ST_END;
                                end
                            end
                            default: begin
                                if (rx_data == EOF) begin
                                    state_d     = ST_ISSUE;
                                    cfg_valid_d = 1'b1;
                                end else begin
                                    state_d     = ST_IDLE;
                                    frame_err_d = 1'b1;
                                    err_code_d  = ERR_BAD_END;
                                end
                            end
                        endcase
                    end
                end else if (tmo_expired) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                end
            end
            ST_ISSUE: begin
                if (rx_valid) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
                if (cfg_ready) begin
                    state_d     = ST_IDLE;
                    cfg_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cfg_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            chk_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            cfg_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            chk_q       <= chk_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            cfg_valid_q <= cfg_valid_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign cfg_valid = cfg_valid_q;
    assign cfg_addr  = cfg_q.addr;
    assign cfg_data  = cfg_q.data;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cfg_frame_controller.sv
// Directed bench for cfg_frame_controller: good frames, handshake stall, each error path, reset abort.
module tb_cfg_frame_controller;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_addr;
    logic [27:0] cfg_data;
    logic        frame_err;
    logic [2:0]  err_code;
    logic        busy;

    int tests_run;
    int tests_failed;
    int valid_cycles;
    int v0;
    int hold;
    int unstable;

    cfg_frame_controller #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles on which a write is offered
    always @(posedge clk) begin
        if (cfg_valid) valid_cycles++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One byte strobed for one cycle; returns on the falling edge after it was consumed
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d3, input logic [7:0] d2,
                              input logic [7:0] d1, input logic [7:0] d0, input logic [7:0] chk);
        send_byte(8'hFF);
        send_byte(a);
        send_byte(d3);
        send_byte(d2);
        send_byte(d1);
        send_byte(d0);
        send_byte(chk);
        send_byte(8'hFE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        valid_cycles = 0;
        rst_n        = 1'b0;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        cfg_ready    = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(cfg_valid), 32'd0);
        check_eq("rst_addr",  32'(cfg_addr),  32'd0);
        check_eq("rst_data",  32'(cfg_data),  32'd0);
        check_eq("rst_err",   32'(frame_err), 32'd0);
        check_eq("rst_code",  32'(err_code),  32'd0);
        check_eq("rst_busy",  32'(busy),      32'd0);
        rst_n = 1'b1;

        // Good frame, ready tied high: single-cycle write; 00^01^23^45^67 = 00
        v0 = valid_cycles;
        send_frame(8'h00, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00);
        check_eq("a_valid", 32'(cfg_valid), 32'd1);
        check_eq("a_addr",  32'(cfg_addr),  32'd0);
        check_eq("a_data",  32'(cfg_data),  32'h1234567);
        check_eq("a_busy",  32'(busy),      32'd1);
        @(negedge clk);
        check_eq("a_drop",   32'(cfg_valid),     32'd0);
        check_eq("a_idle",   32'(busy),          32'd0);
        check_eq("a_pulses", 32'(valid_cycles - v0), 32'd1);
        check_eq("a_code",   32'(err_code),      32'd0);

        // Stalled handshake: ready low 5 cycles, byte injected during ISSUE -> overrun
        cfg_ready = 1'b0;
        send_frame(8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h09);
        hold     = 0;
        unstable = 0;
        for (int i = 0; i < 12 && cfg_valid; i++) begin
            hold++;
            if (cfg_addr !== 2'd3 || cfg_data !== 28'h000000A) unstable++;
            if (i == 0) begin
                rx_data  = 8'h55;
                rx_valid = 1'b1;
            end
            if (i == 1) begin
                rx_valid = 1'b0;
                check_eq("b_ovr_err",  32'(frame_err), 32'd1);
                check_eq("b_ovr_code", 32'(err_code),  32'd6);
            end
            if (i == 2) check_eq("b_err_pulse", 32'(frame_err), 32'd0);
            if (i == 5) cfg_ready = 1'b1;
            @(negedge clk);
        end
        check_eq("b_hold",     32'(hold),      32'd6);
        check_eq("b_stable",   32'(unstable),  32'd0);
        check_eq("b_drop",     32'(cfg_valid), 32'd0);
        check_eq("b_idle",     32'(busy),      32'd0);

        // Wrong checksum: bad_chk, terminator then ignored, no write
        v0 = valid_cycles;
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h23);
        send_byte(8'h45);
        send_byte(8'h67);
        send_byte(8'h66);
        check_eq("c_err",  32'(frame_err), 32'd1);
        check_eq("c_code", 32'(err_code),  32'd3);
        check_eq("c_busy", 32'(busy),      32'd0);
        send_byte(8'hFE);
        repeat (2) @(negedge clk);
        check_eq("c_nowrite", 32'(valid_cycles - v0), 32'd0);

        // Overflow in D3 reported only at checksum time; 02^10 = 12
        send_byte(8'hFF);
        send_byte(8'h02);
        send_byte(8'h10);
        check_eq("d_no_early", 32'(frame_err), 32'd0);
        check_eq("d_busy",     32'(busy),      32'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h12);
        check_eq("d_err",  32'(frame_err), 32'd1);
        check_eq("d_code", 32'(err_code),  32'd2);
        check_eq("d_idle", 32'(busy),      32'd0);

        // Bad address flagged right after the address byte
        send_byte(8'hFF);
        send_byte(8'h05);
        check_eq("e_err",  32'(frame_err), 32'd1);
        check_eq("e_code", 32'(err_code),  32'd1);
        check_eq("e_idle", 32'(busy),      32'd0);

        // Inter-byte timeout after exactly 16 idle cycles
        send_byte(8'hFF);
        send_byte(8'h01);
        send_byte(8'h12);
        repeat (15) @(negedge clk);
        check_eq("f_pre_busy", 32'(busy),      32'd1);
        check_eq("f_pre_err",  32'(frame_err), 32'd0);
        @(negedge clk);
        check_eq("f_err",  32'(frame_err), 32'd1);
        check_eq("f_code", 32'(err_code),  32'd7);
        check_eq("f_idle", 32'(busy),      32'd0);
        // Recovery frame: 02^00^00^12^34 = 24
        send_frame(8'h02, 8'h00, 8'h00, 8'h12, 8'h34, 8'h24);
        check_eq("f_valid", 32'(cfg_valid), 32'd1);
        check_eq("f_addr",  32'(cfg_addr),  32'd2);
        check_eq("f_data",  32'(cfg_data),  32'h0001234);
        @(negedge clk);

        // Resync on mid-frame start byte, then reset during ISSUE abandons the write
        cfg_ready = 1'b0;
        send_byte(8'hFF);
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'hFF);
        check_eq("g_err",  32'(frame_err), 32'd1);
        check_eq("g_code", 32'(err_code),  32'd5);
        check_eq("g_busy", 32'(busy),      32'd1);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h04);
        send_byte(8'hFE);
        check_eq("g_valid", 32'(cfg_valid), 32'd1);
        check_eq("g_addr",  32'(cfg_addr),  32'd1);
        check_eq("g_data",  32'(cfg_data),  32'h0000005);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("g_rst_valid", 32'(cfg_valid), 32'd0);
        check_eq("g_rst_busy",  32'(busy),      32'd0);
        check_eq("g_rst_code",  32'(err_code),  32'd0);
        rst_n     = 1'b1;
        cfg_ready = 1'b1;
        @(negedge clk);
        check_eq("g_no_pulse", 32'(cfg_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
